decode_stage: RTL and testbench



---
 rtl/decode_stage.sv | 355 +++++++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I (+ optional M) instruction-decode pipeline stage.
// Decodes one instruction per cycle into the execute-stage control bundle and
// holds it under backpressure. Undecodable instructions produce an all-zero
// control bundle with out_illegal set and bump a saturating event counter.
//
// Handshake (both sides): a beat moves when valid & ready on a rising edge.
// A producer holds valid and its payload stable until ready is seen, and a
// consumer may raise ready independently of valid. The stage accepts a new
// instruction whenever its output register is empty or being drained this
// cycle (in_ready = ~out_valid | out_ready), and flush drops both the held
// bundle and any same-cycle input.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [XLEN-1:0]  out_imm,
  output logic [5:0]       out_alu_control,
  output logic             out_reg_write,
  output logic             out_alu_src,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             out_mem_to_reg,
  output logic [1:0]       out_mem_size,
  output logic             out_mem_unsigned,
  output logic             out_branch,
  output logic             out_jump,
  output logic             out_jalr,
  output logic             out_lui,
  output logic             out_auipc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  // Major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULT = 7'b0000001;

  // ALU operation codes
  localparam logic [5:0] ALU_ADD   = 6'd1;
  localparam logic [5:0] ALU_SUB   = 6'd2;
  localparam logic [5:0] ALU_SLL   = 6'd3;
  localparam logic [5:0] ALU_SLT   = 6'd4;
  localparam logic [5:0] ALU_SLTU  = 6'd5;
  localparam logic [5:0] ALU_XOR   = 6'd6;
  localparam logic [5:0] ALU_SRL   = 6'd7;
  localparam logic [5:0] ALU_SRA   = 6'd8;
  localparam logic [5:0] ALU_OR    = 6'd9;
  localparam logic [5:0] ALU_AND   = 6'd10;
  localparam logic [5:0] ALU_ADDI  = 6'd11;
  localparam logic [5:0] ALU_SLLI  = 6'd12;
  localparam logic [5:0] ALU_SLTI  = 6'd13;
  localparam logic [5:0] ALU_SLTIU = 6'd14;
  localparam logic [5:0] ALU_XORI  = 6'd15;
  localparam logic [5:0] ALU_SRLI  = 6'd16;
  localparam logic [5:0] ALU_ORI   = 6'd17;
  localparam logic [5:0] ALU_ANDI  = 6'd18;
  localparam logic [5:0] ALU_SRAI  = 6'd19;
  localparam logic [5:0] ALU_BEQ   = 6'd27;
  localparam logic [5:0] ALU_BNE   = 6'd28;
  localparam logic [5:0] ALU_BLTU  = 6'd29;
  localparam logic [5:0] ALU_BGEU  = 6'd30;
  localparam logic [5:0] ALU_BGE   = 6'd31;
  localparam logic [5:0] ALU_BLT   = 6'd32;
  localparam logic [5:0] ALU_LUI   = 6'd33;
  localparam logic [5:0] ALU_JAL   = 6'd34;
  localparam logic [5:0] ALU_JALR  = 6'd35;
  localparam logic [5:0] ALU_AUIPC = 6'd36;
  localparam logic [5:0] ALU_MUL   = 6'd37;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [5:0]      alu_control;
    logic            reg_write;
    logic            alu_src;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic            branch;
    logic            jump;
    logic            jalr;
    logic            lui;
    logic            auipc;
    logic            illegal;
  } bundle_t;

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic               legal;
  logic signed [31:0] imm32;
  bundle_t            dec;
  bundle_t            out_q;
  logic               accept;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  assign in_ready = reset | ~out_valid | out_ready;
  assign accept   = in_valid & in_ready & ~flush;

  // Combinational decode of the incoming instruction into a full bundle
  always_comb begin
    dec       = '0;
    legal     = 1'b0;
    imm32     = '0;
    dec.pc    = in_pc;
    dec.rd    = in_instr[11:7];
    dec.rs1   = in_instr[19:15];
    dec.rs2   = in_instr[24:20];

    if (in_instr[1:0] == 2'b11) begin
      case (opcode)
        OP_R: begin
          dec.reg_write = 1'b1;
          case (funct7)
            F7_BASE: begin
              legal = 1'b1;
              case (funct3)
                3'b000:  dec.alu_control = ALU_ADD;
                3'b001:  dec.alu_control = ALU_SLL;
                3'b010:  dec.alu_control = ALU_SLT;
                3'b011:  dec.alu_control = ALU_SLTU;
                3'b100:  dec.alu_control = ALU_XOR;
                3'b101:  dec.alu_control = ALU_SRL;
                3'b110:  dec.alu_control = ALU_OR;
                default: dec.alu_control = ALU_AND;
              endcase
            end
            F7_ALT: begin
              if (funct3 == 3'b000) begin
                legal = 1'b1;
                dec.alu_control = ALU_SUB;
              end else if (funct3 == 3'b101) begin
                legal = 1'b1;
                dec.alu_control = ALU_SRA;
              end
            end
            F7_MULT: begin
              if (ENABLE_M != 0) begin
                legal = 1'b1;
                dec.alu_control = ALU_MUL + {3'b000, funct3};
              end
            end
            default: ;
          endcase
        end

        OP_IMM: begin
          dec.reg_write = 1'b1;
          dec.alu_src   = 1'b1;
          imm32         = {{20{in_instr[31]}}, in_instr[31:20]};
          case (funct3)
            3'b000: begin legal = 1'b1; dec.alu_control = ALU_ADDI;  end
            3'b010: begin legal = 1'b1; dec.alu_control = ALU_SLTI;  end
            3'b011: begin legal = 1'b1; dec.alu_control = ALU_SLTIU; end
            3'b100: begin legal = 1'b1; dec.alu_control = ALU_XORI;  end
            3'b110: begin legal = 1'b1; dec.alu_control = ALU_ORI;   end
            3'b111: begin legal = 1'b1; dec.alu_control = ALU_ANDI;  end
            3'b001: begin
              if (funct7 == F7_BASE) begin
                legal = 1'b1;
                dec.alu_control = ALU_SLLI;
              end
            end
            default: begin
              if (funct7 == F7_BASE) begin
                legal = 1'b1;
                dec.alu_control = ALU_SRLI;
              end else if (funct7 == F7_ALT) begin
                legal = 1'b1;
                dec.alu_control = ALU_SRAI;
              end
            end
          endcase
        end

        OP_LOAD: begin
          // funct3[1:0] is the access size, funct3[2] marks zero-extension
          legal            = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
          dec.reg_write    = 1'b1;
          dec.alu_src      = 1'b1;
          dec.mem_read     = 1'b1;
          dec.mem_to_reg   = 1'b1;
          dec.mem_size     = funct3[1:0];
          dec.mem_unsigned = funct3[2];
          dec.alu_control  = ALU_ADDI;
          imm32            = {{20{in_instr[31]}}, in_instr[31:20]};
        end

        OP_STORE: begin
          legal           = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
          dec.alu_src     = 1'b1;
          dec.mem_write   = 1'b1;
          dec.mem_size    = funct3[1:0];
          dec.alu_control = ALU_ADDI;
          imm32           = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        end

        OP_BRANCH: begin
          dec.branch = 1'b1;
          imm32      = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
          case (funct3)
            3'b000: begin legal = 1'b1; dec.alu_control = ALU_BEQ;  end
            3'b001: begin legal = 1'b1; dec.alu_control = ALU_BNE;  end
            3'b100: begin legal = 1'b1; dec.alu_control = ALU_BLT;  end
            3'b101: begin legal = 1'b1; dec.alu_control = ALU_BGE;  end
            3'b110: begin legal = 1'b1; dec.alu_control = ALU_BLTU; end
            3'b111: begin legal = 1'b1; dec.alu_control = ALU_BGEU; end
            default: ;
          endcase
        end

        OP_LUI: begin
          legal           = 1'b1;
          dec.reg_write   = 1'b1;
          dec.alu_src     = 1'b1;
          dec.lui         = 1'b1;
          dec.alu_control = ALU_LUI;
          imm32           = {in_instr[31:12], 12'b0};
        end

        OP_AUIPC: begin
          legal           = 1'b1;
          dec.reg_write   = 1'b1;
          dec.alu_src     = 1'b1;
          dec.auipc       = 1'b1;
          dec.alu_control = ALU_AUIPC;
          imm32           = {in_instr[31:12], 12'b0};
        end

        OP_JAL: begin
          legal           = 1'b1;
          dec.reg_write   = 1'b1;
          dec.jump        = 1'b1;
          dec.alu_control = ALU_JAL;
          imm32           = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
        end

        OP_JALR: begin
          legal           = (funct3 == 3'b000);
          dec.reg_write   = 1'b1;
          dec.alu_src     = 1'b1;
          dec.jalr        = 1'b1;
          dec.alu_control = ALU_JALR;
          imm32           = {{20{in_instr[31]}}, in_instr[31:20]};
        end

        default: ;
      endcase
    end

    dec.imm = XLEN'(imm32);

    // An undecodable word keeps its PC and register fields but no control
    if (!legal) begin
      dec.imm          = '0;
      dec.alu_control  = '0;
      dec.reg_write    = 1'b0;
      dec.alu_src      = 1'b0;
      dec.mem_read     = 1'b0;
      dec.mem_write    = 1'b0;
      dec.mem_to_reg   = 1'b0;
      dec.mem_size     = '0;
      dec.mem_unsigned = 1'b0;
      dec.branch       = 1'b0;
      dec.jump         = 1'b0;
      dec.jalr         = 1'b0;
      dec.lui          = 1'b0;
      dec.auipc        = 1'b0;
      dec.illegal      = 1'b1;
    end

    // x0 is hard-wired, so never request a write to it
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
  end

  // Output register: capture on transfer, drain on consume, drop on flush
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_q     <= dec;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of illegal instructions actually accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_count <= '0;
    end else if (accept && dec.illegal && (illegal_count != {CNT_W{1'b1}})) begin
      illegal_count <= illegal_count + 1'b1;
    end
  end

  assign out_pc           = out_q.pc;
  assign out_rd           = out_q.rd;
  assign out_rs1          = out_q.rs1;
  assign out_rs2          = out_q.rs2;
  assign out_imm          = out_q.imm;
  assign out_alu_control  = out_q.alu_control;
  assign out_reg_write    = out_q.reg_write;
  assign out_alu_src      = out_q.alu_src;
  assign out_mem_read     = out_q.mem_read;
  assign out_mem_write    = out_q.mem_write;
  assign out_mem_to_reg   = out_q.mem_to_reg;
  assign out_mem_size     = out_q.mem_size;
  assign out_mem_unsigned = out_q.mem_unsigned;
  assign out_branch       = out_q.branch;
  assign out_jump         = out_q.jump;
  assign out_jalr         = out_q.jalr;
  assign out_lui          = out_q.lui;
  assign out_auipc        = out_q.auipc;
  assign out_illegal      = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: two decode_stage instances (M disabled with a 4-bit counter,
// M enabled with a 16-bit counter) share one stimulus stream. A mask/match
// opcode table predicts each decoded bundle; a one-deep expected queue per
// instance models the stage's occupancy.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [5:0]  alu_control;
    logic        reg_write;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic        lui;
    logic        auipc;
    logic        illegal;
  } bundle_t;

  localparam int BW = $bits(bundle_t);

  localparam int K_R = 0, K_M = 1, K_IMM = 2, K_LOAD = 3, K_STORE = 4;
  localparam int K_BR = 5, K_LUI = 6, K_AUIPC = 7, K_JAL = 8, K_JALR = 9;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  logic flush;
  logic in_valid;
  logic out_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 0: ENABLE_M=0, CNT_W=4 ----------------
  logic d0_in_ready, d0_out_valid;
  logic [31:0] d0_out_pc, d0_out_imm;
  logic [4:0] d0_out_rd, d0_out_rs1, d0_out_rs2;
  logic [5:0] d0_out_alu_control;
  logic d0_out_reg_write, d0_out_alu_src, d0_out_mem_read, d0_out_mem_write, d0_out_mem_to_reg;
  logic [1:0] d0_out_mem_size;
  logic d0_out_mem_unsigned, d0_out_branch, d0_out_jump, d0_out_jalr, d0_out_lui, d0_out_auipc;
  logic d0_out_illegal;
  logic [3:0] d0_illegal_count;

  decode_stage #(.XLEN(32), .ENABLE_M(0), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(d0_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(d0_out_valid), .out_ready(out_ready),
    .out_pc(d0_out_pc), .out_rd(d0_out_rd), .out_rs1(d0_out_rs1), .out_rs2(d0_out_rs2),
    .out_imm(d0_out_imm), .out_alu_control(d0_out_alu_control),
    .out_reg_write(d0_out_reg_write), .out_alu_src(d0_out_alu_src),
    .out_mem_read(d0_out_mem_read), .out_mem_write(d0_out_mem_write),
    .out_mem_to_reg(d0_out_mem_to_reg), .out_mem_size(d0_out_mem_size),
    .out_mem_unsigned(d0_out_mem_unsigned), .out_branch(d0_out_branch),
    .out_jump(d0_out_jump), .out_jalr(d0_out_jalr), .out_lui(d0_out_lui),
    .out_auipc(d0_out_auipc), .out_illegal(d0_out_illegal),
    .illegal_count(d0_illegal_count)
  );

  // ---------------- DUT 1: ENABLE_M=1, CNT_W=16 ----------------
  logic d1_in_ready, d1_out_valid;
  logic [31:0] d1_out_pc, d1_out_imm;
  logic [4:0] d1_out_rd, d1_out_rs1, d1_out_rs2;
  logic [5:0] d1_out_alu_control;
  logic d1_out_reg_write, d1_out_alu_src, d1_out_mem_read, d1_out_mem_write, d1_out_mem_to_reg;
  logic [1:0] d1_out_mem_size;
  logic d1_out_mem_unsigned, d1_out_branch, d1_out_jump, d1_out_jalr, d1_out_lui, d1_out_auipc;
  logic d1_out_illegal;
  logic [15:0] d1_illegal_count;

  decode_stage #(.XLEN(32), .ENABLE_M(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(d1_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(d1_out_valid), .out_ready(out_ready),
    .out_pc(d1_out_pc), .out_rd(d1_out_rd), .out_rs1(d1_out_rs1), .out_rs2(d1_out_rs2),
    .out_imm(d1_out_imm), .out_alu_control(d1_out_alu_control),
    .out_reg_write(d1_out_reg_write), .out_alu_src(d1_out_alu_src),
    .out_mem_read(d1_out_mem_read), .out_mem_write(d1_out_mem_write),
    .out_mem_to_reg(d1_out_mem_to_reg), .out_mem_size(d1_out_mem_size),
    .out_mem_unsigned(d1_out_mem_unsigned), .out_branch(d1_out_branch),
    .out_jump(d1_out_jump), .out_jalr(d1_out_jalr), .out_lui(d1_out_lui),
    .out_auipc(d1_out_auipc), .out_illegal(d1_out_illegal),
    .illegal_count(d1_illegal_count)
  );

  logic [BW-1:0] obs0, obs1;
  assign obs0 = {d0_out_pc, d0_out_rd, d0_out_rs1, d0_out_rs2, d0_out_imm, d0_out_alu_control,
                 d0_out_reg_write, d0_out_alu_src, d0_out_mem_read, d0_out_mem_write,
                 d0_out_mem_to_reg, d0_out_mem_size, d0_out_mem_unsigned, d0_out_branch,
                 d0_out_jump, d0_out_jalr, d0_out_lui, d0_out_auipc, d0_out_illegal};
  assign obs1 = {d1_out_pc, d1_out_rd, d1_out_rs1, d1_out_rs2, d1_out_imm, d1_out_alu_control,
                 d1_out_reg_write, d1_out_alu_src, d1_out_mem_read, d1_out_mem_write,
                 d1_out_mem_to_reg, d1_out_mem_size, d1_out_mem_unsigned, d1_out_branch,
                 d1_out_jump, d1_out_jalr, d1_out_lui, d1_out_auipc, d1_out_illegal};

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [BW-1:0] exp_q0[$];
  logic [BW-1:0] exp_q1[$];
  int cnt0 = 0;
  int cnt1 = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model: instruction mask/match table ----------------
  logic [31:0] t_mask[$];
  logic [31:0] t_match[$];
  int          t_alu[$];
  int          t_kind[$];
  logic [1:0]  t_size[$];
  logic        t_uns[$];

  task automatic add_ent(input logic [31:0] mask, input logic [31:0] match, input int alu,
                         input int kind, input logic [1:0] size, input logic uns);
    t_mask.push_back(mask);
    t_match.push_back(match);
    t_alu.push_back(alu);
    t_kind.push_back(kind);
    t_size.push_back(size);
    t_uns.push_back(uns);
  endtask

  function automatic logic [31:0] enc(input int f7, input int f3, input int op);
    return (32'(f7) << 25) | (32'(f3) << 12) | 32'(op);
  endfunction

  task automatic build_table();
    int r_alu[8] = '{1, 3, 4, 5, 6, 7, 9, 10};
    int i_alu[8] = '{11, 12, 13, 14, 15, 16, 17, 18};
    int b_alu[8] = '{27, 28, 0, 0, 32, 31, 29, 30};
    for (int f = 0; f < 8; f++) begin
      add_ent(32'hFE00707F, enc(0, f, 'h33), r_alu[f], K_R, 2'd0, 1'b0);
      add_ent(32'hFE00707F, enc(1, f, 'h33), 37 + f, K_M, 2'd0, 1'b0);
      if (f != 1 && f != 5) add_ent(32'h0000707F, enc(0, f, 'h13), i_alu[f], K_IMM, 2'd0, 1'b0);
      if (f != 2 && f != 3) add_ent(32'h0000707F, enc(0, f, 'h63), b_alu[f], K_BR, 2'd0, 1'b0);
    end
    add_ent(32'hFE00707F, enc('h20, 0, 'h33), 2, K_R, 2'd0, 1'b0);
    add_ent(32'hFE00707F, enc('h20, 5, 'h33), 8, K_R, 2'd0, 1'b0);
    add_ent(32'hFE00707F, enc(0, 1, 'h13), 12, K_IMM, 2'd0, 1'b0);
    add_ent(32'hFE00707F, enc(0, 5, 'h13), 16, K_IMM, 2'd0, 1'b0);
    add_ent(32'hFE00707F, enc('h20, 5, 'h13), 19, K_IMM, 2'd0, 1'b0);
    add_ent(32'h0000707F, enc(0, 0, 'h03), 11, K_LOAD, 2'd0, 1'b0);
    add_ent(32'h0000707F, enc(0, 1, 'h03), 11, K_LOAD, 2'd1, 1'b0);
    add_ent(32'h0000707F, enc(0, 2, 'h03), 11, K_LOAD, 2'd2, 1'b0);
    add_ent(32'h0000707F, enc(0, 4, 'h03), 11, K_LOAD, 2'd0, 1'b1);
    add_ent(32'h0000707F, enc(0, 5, 'h03), 11, K_LOAD, 2'd1, 1'b1);
    add_ent(32'h0000707F, enc(0, 0, 'h23), 11, K_STORE, 2'd0, 1'b0);
    add_ent(32'h0000707F, enc(0, 1, 'h23), 11, K_STORE, 2'd1, 1'b0);
    add_ent(32'h0000707F, enc(0, 2, 'h23), 11, K_STORE, 2'd2, 1'b0);
    add_ent(32'h0000007F, 32'h37, 33, K_LUI, 2'd0, 1'b0);
    add_ent(32'h0000007F, 32'h17, 36, K_AUIPC, 2'd0, 1'b0);
    add_ent(32'h0000007F, 32'h6F, 34, K_JAL, 2'd0, 1'b0);
    add_ent(32'h0000707F, enc(0, 0, 'h67), 35, K_JALR, 2'd0, 1'b0);
  endtask

  function automatic bundle_t model(input logic [31:0] ins, input logic [31:0] pc, input bit m_en);
    bundle_t b;
    int hit;
    logic signed [31:0] si;
    logic [31:0] ar20, ar19, ar11, imm_i, imm_s, imm_b, imm_u, imm_j;
    si   = ins;
    ar20 = si >>> 20;
    ar19 = si >>> 19;
    ar11 = si >>> 11;
    imm_i = ar20;
    imm_s = (ar20 & 32'hFFFFFFE0) | 32'(ins[11:7]);
    imm_b = (ar19 & 32'hFFFFF000) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    imm_u = ins & 32'hFFFFF000;
    imm_j = (ar11 & 32'hFFF00000) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    hit = -1;
    for (int i = 0; i < t_mask.size(); i++)
      if (((ins & t_mask[i]) == t_match[i]) && (t_kind[i] != K_M || m_en)) hit = i;
    b     = '0;
    b.pc  = pc;
    b.rd  = ins[11:7];
    b.rs1 = ins[19:15];
    b.rs2 = ins[24:20];
    if (hit < 0) begin
      b.illegal = 1'b1;
      return b;
    end
    b.alu_control = 6'(t_alu[hit]);
    case (t_kind[hit])
      K_R, K_M: b.reg_write = 1'b1;
      K_IMM:    begin b.reg_write = 1'b1; b.alu_src = 1'b1; b.imm = imm_i; end
      K_LOAD:   begin
        b.reg_write = 1'b1; b.alu_src = 1'b1; b.mem_read = 1'b1; b.mem_to_reg = 1'b1;
        b.mem_size = t_size[hit]; b.mem_unsigned = t_uns[hit]; b.imm = imm_i;
      end
      K_STORE:  begin b.alu_src = 1'b1; b.mem_write = 1'b1; b.mem_size = t_size[hit]; b.imm = imm_s; end
      K_BR:     begin b.branch = 1'b1; b.imm = imm_b; end
      K_LUI:    begin b.reg_write = 1'b1; b.alu_src = 1'b1; b.lui = 1'b1; b.imm = imm_u; end
      K_AUIPC:  begin b.reg_write = 1'b1; b.alu_src = 1'b1; b.auipc = 1'b1; b.imm = imm_u; end
      K_JAL:    begin b.reg_write = 1'b1; b.jump = 1'b1; b.imm = imm_j; end
      default:  begin b.reg_write = 1'b1; b.alu_src = 1'b1; b.jalr = 1'b1; b.imm = imm_i; end
    endcase
    if (b.rd == 5'd0) b.reg_write = 1'b0;
    return b;
  endfunction

  function automatic logic [31:0] gen_instr();
    int r;
    int idx;
    r = $urandom_range(0, 9);
    if (r == 0) return $urandom;
    if (r == 1) return $urandom | 32'h3;
    idx = $urandom_range(0, t_mask.size() - 1);
    return t_match[idx] | ($urandom & ~t_mask[idx]);
  endfunction

  // ---------------- driver ----------------
  // One cycle: drive inputs after the falling edge, check the presented state,
  // advance the occupancy model across the next rising edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    bit rdy0, rdy1;
    bundle_t e;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    rdy0 = (exp_q0.size() == 0) || ordy;
    rdy1 = (exp_q1.size() == 0) || ordy;
    check("d0_valid", 128'(d0_out_valid), 128'(exp_q0.size() != 0));
    check("d1_valid", 128'(d1_out_valid), 128'(exp_q1.size() != 0));
    check("d0_in_ready", 128'(d0_in_ready), 128'(rdy0));
    check("d1_in_ready", 128'(d1_in_ready), 128'(rdy1));
    if (exp_q0.size() != 0) check("d0_bundle", 128'(obs0), 128'(exp_q0[0]));
    if (exp_q1.size() != 0) check("d1_bundle", 128'(obs1), 128'(exp_q1[0]));
    check("d0_count", 128'(d0_illegal_count), 128'(cnt0));
    check("d1_count", 128'(d1_illegal_count), 128'(cnt1));
    if (exp_q0.size() != 0 && ordy) void'(exp_q0.pop_front());
    if (exp_q1.size() != 0 && ordy) void'(exp_q1.pop_front());
    if (fl) begin
      exp_q0.delete();
      exp_q1.delete();
    end else if (v) begin
      if (rdy0) begin
        e = model(ins, pc, 1'b0);
        exp_q0.push_back(e);
        if (e.illegal && cnt0 < 15) cnt0++;
      end
      if (rdy1) begin
        e = model(ins, pc, 1'b1);
        exp_q1.push_back(e);
        if (e.illegal && cnt1 < 65535) cnt1++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic v, input logic [31:0] ins);
    reset = 1'b1; in_valid = v; in_instr = ins; in_pc = $urandom;
    out_ready = 1'($urandom_range(0, 1)); flush = 1'b0;
    #1;
    check("d0_ready_in_reset", 128'(d0_in_ready), 128'(1));
    check("d1_ready_in_reset", 128'(d1_in_ready), 128'(1));
    @(posedge clk);
    @(negedge clk);
    check("d0_valid_after_reset", 128'(d0_out_valid), 128'(0));
    check("d1_valid_after_reset", 128'(d1_out_valid), 128'(0));
    check("d0_bundle_after_reset", 128'(obs0), 128'(0));
    check("d1_bundle_after_reset", 128'(obs1), 128'(0));
    check("d0_count_after_reset", 128'(d0_illegal_count), 128'(0));
    check("d1_count_after_reset", 128'(d1_illegal_count), 128'(0));
    reset = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    cnt0 = 0;
    cnt1 = 0;
  endtask

  // ---------------- stimulus ----------------
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LHU  = 32'hFFC35283;
  localparam logic [31:0] I_BGEU = 32'h0020F463;
  localparam logic [31:0] I_JALR = 32'h000100E7;
  localparam logic [31:0] I_MUL  = 32'h022081B3;
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    build_table();
    @(negedge clk);
    do_reset(1'b1, I_ADD);

    // directed decode cases
    step(1'b1, I_ADD, 32'h100, 1'b1, 1'b0);
    check("add_valid", 128'(d0_out_valid), 128'(1));
    check("add_alu", 128'(d0_out_alu_control), 128'(1));
    check("add_rw", 128'(d0_out_reg_write), 128'(1));
    check("add_rd", 128'(d0_out_rd), 128'(3));
    check("add_rs1", 128'(d0_out_rs1), 128'(1));
    check("add_rs2", 128'(d0_out_rs2), 128'(2));
    check("add_src", 128'(d0_out_alu_src), 128'(0));

    step(1'b1, I_LHU, 32'h104, 1'b1, 1'b0);
    check("lhu_mr", 128'(d0_out_mem_read), 128'(1));
    check("lhu_m2r", 128'(d0_out_mem_to_reg), 128'(1));
    check("lhu_size", 128'(d0_out_mem_size), 128'(1));
    check("lhu_uns", 128'(d0_out_mem_unsigned), 128'(1));
    check("lhu_imm", 128'(d0_out_imm), 128'(32'hFFFFFFFC));
    check("lhu_alu", 128'(d0_out_alu_control), 128'(11));

    step(1'b1, I_BGEU, 32'h108, 1'b1, 1'b0);
    check("bgeu_branch", 128'(d0_out_branch), 128'(1));
    check("bgeu_alu", 128'(d0_out_alu_control), 128'(30));
    check("bgeu_imm", 128'(d0_out_imm), 128'(8));
    check("bgeu_rw", 128'(d0_out_reg_write), 128'(0));

    step(1'b1, I_JALR, 32'h10C, 1'b1, 1'b0);
    check("jalr_flag", 128'(d0_out_jalr), 128'(1));
    check("jalr_alu", 128'(d0_out_alu_control), 128'(35));

    step(1'b1, I_MUL, 32'h110, 1'b1, 1'b0);
    check("mul_m0_illegal", 128'(d0_out_illegal), 128'(1));
    check("mul_m0_rw", 128'(d0_out_reg_write), 128'(0));
    check("mul_m0_count", 128'(d0_illegal_count), 128'(1));
    check("mul_m1_alu", 128'(d1_out_alu_control), 128'(37));
    check("mul_m1_illegal", 128'(d1_out_illegal), 128'(0));
    check("mul_m1_count", 128'(d1_illegal_count), 128'(0));

    // backpressure: held bundle must stay put, next one follows without loss
    step(1'b1, I_ADD, 32'h200, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, I_LHU, 32'h204, 1'b0, 1'b0);
      check("bp_hold_pc", 128'(d0_out_pc), 128'(32'h200));
    end
    check("bp_in_ready", 128'(d0_in_ready), 128'(0));
    step(1'b1, I_LHU, 32'h204, 1'b1, 1'b0);
    check("bp_next_pc", 128'(d0_out_pc), 128'(32'h204));
    check("bp_next_valid", 128'(d0_out_valid), 128'(1));
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("bp_drained", 128'(d0_out_valid), 128'(0));

    // flush drops both held and incoming, illegal incoming not counted
    step(1'b1, I_ADD, 32'h300, 1'b1, 1'b0);
    step(1'b1, I_BAD, 32'h304, 1'b0, 1'b1);
    check("flush_valid", 128'(d0_out_valid), 128'(0));
    check("flush_count", 128'(d0_illegal_count), 128'(1));

    // counter saturation on the 4-bit instance
    for (int i = 0; i < 20; i++) step(1'b1, I_BAD, 32'h400 + 32'(i * 4), 1'b1, 1'b0);
    check("sat_count_d0", 128'(d0_illegal_count), 128'(15));
    check("sat_count_d1", 128'(d1_illegal_count), 128'(20));

    // reset while a bundle is held
    step(1'b1, I_ADD, 32'h500, 1'b0, 1'b0);
    do_reset(1'b1, I_LHU);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1'($urandom_range(0, 1)), gen_instr());
      end else begin
        step(1'($urandom_range(0, 3) != 0), gen_instr(), $urandom,
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
      end
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
